// File: rtl/seg7_scan_decoder.sv
// Recovers a 0..9999 value from a multiplexed 4-digit active-low 7-segment scan.
// Frames are filtered for stability before being published on value/dp.
module seg7_scan_decoder #(
   parameter int STABLE_FRAMES  = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  seg,
   input  logic [3:0]  digit,
   output logic [13:0] value,
   output logic        value_valid,
   output logic        update,
   output logic [3:0]  dp,
   output logic        frame_error,
   output logic [7:0]  err_count,
   output logic        stale
);

   localparam int              IW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]      STABLE    = 4'(STABLE_FRAMES);
   localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0]   IDLE_MAX  = IW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {WAIT, HAVE0, HAVE1, HAVE2} state_t;

   state_t          state;
   logic [7:0]      seg_r;
   logic [3:0]      digit_r;
   logic [3:0]      last_sel;
   logic [2:0][3:0] dig_q;
   logic [2:0]      blank_q;
   logic [2:0]      dp_q;
   logic [13:0]     prev_value;
   logic [3:0]      prev_dp;
   logic [3:0]      match_cnt;
   logic [IW-1:0]   idle_cnt;

   logic [3:0]  cur_d;
   logic        cur_blank;
   logic        cur_illegal;
   logic        cur_dp;
   logic [3:0]  expect_sel;
   logic        onehot;
   logic        multi;
   logic        hold;
   logic        in_order;
   logic        complete;
   logic        blank_err;
   logic        err_evt;
   logic        frame_same;
   logic        write_out;
   logic [13:0] frame_value;
   logic [3:0]  frame_dp;
   logic [3:0]  match_next;

   always_comb begin
      cur_d       = 4'd0;
      cur_blank   = 1'b0;
      cur_illegal = 1'b0;
      case (seg_r[6:0])
         7'b0000001: cur_d = 4'd0;
         7'b1001111: cur_d = 4'd1;
         7'b0100100: cur_d = 4'd2;
         7'b0000110: cur_d = 4'd3;
         7'b1001100: cur_d = 4'd4;
         7'b0010010: cur_d = 4'd5;
         7'b0100000: cur_d = 4'd6;
         7'b0001111: cur_d = 4'd7;
         7'b0000000: cur_d = 4'd8;
         7'b0000100: cur_d = 4'd9;
         7'b1111111: cur_blank = 1'b1;
         default:    cur_illegal = 1'b1;
      endcase
   end

   always_comb begin
      expect_sel = 4'b0001;
      case (state)
         WAIT:  expect_sel = 4'b0001;
         HAVE0: expect_sel = 4'b0010;
         HAVE1: expect_sel = 4'b0100;
         HAVE2: expect_sel = 4'b1000;
         default: expect_sel = 4'b0001;
      endcase
   end

   // A repeat of the last accepted select is a hold, even across idle gaps.
   assign cur_dp    = ~seg_r[7];
   assign onehot    = $onehot(digit_r);
   assign multi     = (digit_r != 4'b0000) && !onehot;
   assign hold      = onehot && (digit_r == last_sel);
   assign in_order  = onehot && !hold && (digit_r == expect_sel);
   assign complete  = in_order && !cur_illegal && (state == HAVE2);
   assign blank_err = blank_q[0] | (blank_q[1] & ~blank_q[2]) | (blank_q[2] & ~cur_blank);
   assign err_evt   = multi | (onehot & cur_illegal) | (onehot & ~cur_illegal & ~hold & ~in_order)
                    | (complete & blank_err);

   // Blank digits carry cur_d = 0, so leading blanks fall out of the sum as zero.
   assign frame_value = 14'(cur_d) * 14'd1000 + 14'(dig_q[2]) * 14'd100
                      + 14'(dig_q[1]) * 14'd10 + 14'(dig_q[0]);
   assign frame_dp    = {cur_dp, dp_q};
   assign frame_same  = (match_cnt != 4'd0) && (frame_value == prev_value) && (frame_dp == prev_dp);
   assign match_next  = !frame_same ? 4'd1 : (match_cnt >= STABLE) ? STABLE : match_cnt + 4'd1;
   assign write_out   = (match_next == STABLE) && (!value_valid || frame_value != value || frame_dp != dp);

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_r       <= 8'hFF;
         digit_r     <= 4'b0000;
         state       <= WAIT;
         last_sel    <= 4'b0000;
         dig_q       <= '0;
         blank_q     <= '0;
         dp_q        <= '0;
         prev_value  <= '0;
         prev_dp     <= '0;
         match_cnt   <= '0;
         idle_cnt    <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         update      <= 1'b0;
         dp          <= '0;
         frame_error <= 1'b0;
         err_count   <= '0;
         stale       <= 1'b0;
      end else begin
         seg_r       <= seg;
         digit_r     <= digit;
         update      <= 1'b0;
         frame_error <= err_evt;
         if (err_evt && err_count != 8'hFF)
            err_count <= err_count + 8'd1;

         if (onehot) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
            if (cur_illegal) begin
               state     <= WAIT;
               last_sel  <= 4'b0000;
               match_cnt <= '0;
            end else begin
               // Storing unconditionally is safe: positions are always rewritten before use.
               for (int i = 0; i < 3; i++) begin
                  if (digit_r[i]) begin
                     dig_q[i]   <= cur_d;
                     blank_q[i] <= cur_blank;
                     dp_q[i]    <= cur_dp;
                  end
               end
               if (in_order) begin
                  last_sel <= digit_r;
                  case (state)
                     WAIT:  state <= HAVE0;
                     HAVE0: state <= HAVE1;
                     HAVE1: state <= HAVE2;
                     HAVE2: begin
                        state <= WAIT;
                        if (blank_err) begin
                           match_cnt <= '0;
                        end else begin
                           match_cnt  <= match_next;
                           prev_value <= frame_value;
                           prev_dp    <= frame_dp;
                           if (write_out) begin
                              value       <= frame_value;
                              dp          <= frame_dp;
                              value_valid <= 1'b1;
                              update      <= 1'b1;
                           end
                        end
                     end
                     default: state <= WAIT;
                  endcase
               end else if (!hold) begin
                  match_cnt <= '0;
                  if (digit_r == 4'b0001) begin
                     state    <= HAVE0;
                     last_sel <= 4'b0001;
                  end else begin
                     state    <= WAIT;
                     last_sel <= 4'b0000;
                  end
               end
            end
         end else begin
            if (idle_cnt != IDLE_MAX)
               idle_cnt <= idle_cnt + IW'(1);
            if (multi || idle_cnt == IDLE_LAST) begin
               state     <= WAIT;
               last_sel  <= 4'b0000;
               match_cnt <= '0;
            end
            if (idle_cnt == IDLE_LAST)
               stale <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random scans
// compared cycle by cycle against a digit-level reference model.
module tb_seg7_scan_decoder;
   localparam int S = 2;
   localparam int T = 1023;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  seg = 8'hFF;
   logic [3:0]  digit = 4'b0000;
   logic [13:0] value;
   logic        value_valid, update, frame_error, stale;
   logic [3:0]  dp;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.STABLE_FRAMES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .seg(seg), .digit(digit), .value(value),
      .value_valid(value_valid), .update(update), .dp(dp),
      .frame_error(frame_error), .err_count(err_count), .stale(stale)
   );

   int total = 0;
   int bad = 0;

   logic [6:0] lut [10] = '{7'h01, 7'h4F, 7'h24, 7'h06, 7'h4C, 7'h12, 7'h20, 7'h0F, 7'h00, 7'h04};
   int p10 [4] = '{1, 10, 100, 1000};

   // Reference model: digits as integers (-1 = blank), frame progress as a position.
   int         m_dig [4];
   bit         m_dpv [4];
   int         m_val, m_pval, m_errc, m_idle, m_match, m_pos, m_last;
   logic [3:0] m_dpo, m_pdp;
   bit         m_valid, m_upd, m_ferr, m_stale;
   logic [7:0] pend_seg;
   logic [3:0] pend_dig;

   function automatic int decode(input logic [6:0] p);
      if (p == 7'h7F) return -1;
      for (int i = 0; i < 10; i++) if (lut[i] == p) return i;
      return -2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_dpv[i] = 0; end
      m_val = 0; m_pval = 0; m_errc = 0; m_idle = 0; m_match = 0; m_pos = 0; m_last = -1;
      m_dpo = 0; m_pdp = 0; m_valid = 0; m_upd = 0; m_ferr = 0; m_stale = 0;
      pend_seg = 8'hFF; pend_dig = 4'b0000;
   endtask

   task automatic model_err();
      m_ferr = 1;
      if (m_errc < 255) m_errc++;
   endtask

   task automatic model_frame();
      int v; bit ok, seen; logic [3:0] fdp;
      v = 0; ok = 1; seen = 0;
      for (int i = 3; i >= 0; i--) begin
         if (m_dig[i] < 0) begin if (seen) ok = 0; end
         else begin seen = 1; v += m_dig[i] * p10[i]; end
      end
      if (!seen) ok = 0;
      fdp = {m_dpv[3], m_dpv[2], m_dpv[1], m_dpv[0]};
      if (!ok) begin model_err(); m_match = 0; return; end
      if (m_match > 0 && v == m_pval && fdp == m_pdp) begin
         if (m_match < S) m_match++;
      end else m_match = 1;
      m_pval = v; m_pdp = fdp;
      if (m_match == S && (!m_valid || v != m_val || fdp != m_dpo)) begin
         m_val = v; m_dpo = fdp; m_valid = 1; m_upd = 1;
      end
   endtask

   task automatic model_apply(input logic [7:0] s, input logic [3:0] d);
      int n, idx, k;
      m_upd = 0; m_ferr = 0;
      n = $countones(d);
      if (n != 1) begin
         if (m_idle < T) begin
            m_idle++;
            if (m_idle == T) begin m_stale = 1; m_pos = 0; m_last = -1; m_match = 0; end
         end
         if (n > 1) begin model_err(); m_pos = 0; m_last = -1; m_match = 0; end
      end else begin
         m_idle = 0; m_stale = 0;
         idx = 0;
         for (int i = 0; i < 4; i++) if (d[i]) idx = i;
         k = decode(s[6:0]);
         if (k == -2) begin
            model_err(); m_pos = 0; m_last = -1; m_match = 0;
         end else begin
            m_dig[idx] = k; m_dpv[idx] = !s[7];
            if (idx == m_last) begin
               // repeated select only refreshes the stored digit
            end else if (idx == m_pos) begin
               m_last = idx;
               if (idx < 3) m_pos++;
               else begin m_pos = 0; model_frame(); end
            end else begin
               model_err(); m_match = 0;
               if (idx == 0) begin m_pos = 1; m_last = 0; end
               else begin m_pos = 0; m_last = -1; end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else begin
         model_apply(pend_seg, pend_dig);
         pend_seg = seg; pend_dig = digit;
      end
      #1;
   endtask

   task automatic drive(input logic [7:0] s, input logic [3:0] d);
      seg = s; digit = d;
      tick();
   endtask

   task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
      drive(s0, 4'b0001); drive(s1, 4'b0010); drive(s2, 4'b0100); drive(s3, 4'b1000);
   endtask

   task automatic test_reset();
      reset = 1; seg = 8'h00; digit = 4'b1111;
      tick(); tick();
      total++; if (value !== 14'd0) begin bad++; $display("FAIL reset_value: got %0d want 0", value); end
      total++; if ({value_valid, update, frame_error, stale} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {value_valid, update, frame_error, stale}); end
      total++; if ({dp, err_count} !== 12'h000) begin bad++; $display("FAIL reset_dp_err: got %h want 000", {dp, err_count}); end
      reset = 0; seg = 8'hFF; digit = 4'b0000;
   endtask

   task automatic test_basic();
      scan(8'h81, 8'h86, 8'hFF, 8'hFF);
      scan(8'h81, 8'h86, 8'hFF, 8'hFF);
      total++; if (update !== 1'b0) begin bad++; $display("FAIL basic_early_update: got %b want 0", update); end
      drive(8'hFF, 4'b0000);
      total++; if (update !== 1'b1) begin bad++; $display("FAIL basic_update: got %b want 1", update); end
      total++; if (value !== 14'd30) begin bad++; $display("FAIL basic_value: got %0d want 30", value); end
      total++; if ({value_valid, dp} !== 5'b10000) begin bad++; $display("FAIL basic_valid_dp: got %b want 10000", {value_valid, dp}); end
      drive(8'hFF, 4'b0000);
      total++; if (update !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got %b want 0", update); end
   endtask

   task automatic test_stable();
      int ups;
      logic [7:0] fr [4];
      fr = '{8'h81, 8'h81, 8'h81, 8'hCF};
      ups = 0;
      for (int f = 0; f < 5; f++)
         for (int i = 0; i < 4; i++) begin
            drive(fr[i], 4'(1 << i));
            ups += int'(update);
         end
      for (int i = 0; i < 2; i++) begin drive(8'hFF, 4'b0000); ups += int'(update); end
      total++; if (ups != 1) begin bad++; $display("FAIL stable_update_count: got %0d want 1", ups); end
      total++; if (value !== 14'd1000) begin bad++; $display("FAIL stable_value: got %0d want 1000", value); end
   endtask

   task automatic test_bad_select();
      drive(8'h00, 4'b0010);
      total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL badsel_early: got %b want 0", frame_error); end
      drive(8'hFF, 4'b0000);
      total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL badsel_pulse: got %b want 1", frame_error); end
      total++; if (err_count !== 8'd1) begin bad++; $display("FAIL badsel_count: got %0d want 1", err_count); end
      total++; if (value !== 14'd1000) begin bad++; $display("FAIL badsel_value_held: got %0d want 1000", value); end
      drive(8'hFF, 4'b0000);
      total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL badsel_one_cycle: got %b want 0", frame_error); end
      scan(8'h81, 8'hA4, 8'hCF, 8'hFF);
      scan(8'h81, 8'hA4, 8'hCF, 8'hFF);
      drive(8'hFF, 4'b0000);
      total++; if ({update, value} !== {1'b1, 14'd120}) begin bad++; $display("FAIL badsel_recover: got upd=%b val=%0d want upd=1 val=120", update, value); end
   endtask

   task automatic test_order_and_blank();
      drive(8'h81, 4'b0001); drive(8'h81, 4'b0100); drive(8'hFF, 4'b0000);
      total++; if ({frame_error, err_count} !== {1'b1, 8'd2}) begin bad++; $display("FAIL order_err: got fe=%b cnt=%0d want fe=1 cnt=2", frame_error, err_count); end
      scan(8'h92, 8'hCF, 8'hA4, 8'h86);
      scan(8'h92, 8'hCF, 8'hA4, 8'h86);
      drive(8'hFF, 4'b0000);
      total++; if ({update, value} !== {1'b1, 14'd3215}) begin bad++; $display("FAIL order_recover: got upd=%b val=%0d want upd=1 val=3215", update, value); end
      scan(8'hFF, 8'hCF, 8'hCF, 8'hCF);
      drive(8'hFF, 4'b0000);
      total++; if ({frame_error, err_count} !== {1'b1, 8'd3}) begin bad++; $display("FAIL units_blank: got fe=%b cnt=%0d want fe=1 cnt=3", frame_error, err_count); end
      total++; if (value !== 14'd3215) begin bad++; $display("FAIL units_blank_value: got %0d want 3215", value); end
   endtask

   task automatic test_timeout();
      repeat (1000) drive(8'hFF, 4'b0000);
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_early: got %b want 0", stale); end
      repeat (30) drive(8'hFF, 4'b0000);
      total++; if (stale !== 1'b1) begin bad++; $display("FAIL stale_set: got %b want 1", stale); end
      total++; if ({value_valid, value} !== {1'b1, 14'd3215}) begin bad++; $display("FAIL stale_hold: got vv=%b val=%0d want vv=1 val=3215", value_valid, value); end
      drive(8'h81, 4'b0001); drive(8'hFF, 4'b0000);
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_clear: got %b want 0", stale); end
   endtask

   task automatic test_reset_mid();
      drive(8'h81, 4'b0001); drive(8'h86, 4'b0010); drive(8'hFF, 4'b0000);
      reset = 1; tick();
      total++; if ({value, value_valid, update, dp, frame_error, err_count, stale} !== 30'd0) begin bad++; $display("FAIL midreset_outputs: got val=%0d vv=%b upd=%b dp=%h fe=%b cnt=%0d st=%b want all 0", value, value_valid, update, dp, frame_error, err_count, stale); end
      reset = 0;
      drive(8'hCF, 4'b0100); drive(8'hFF, 4'b0000);
      total++; if ({frame_error, err_count} !== {1'b1, 8'd1}) begin bad++; $display("FAIL midreset_discard: got fe=%b cnt=%0d want fe=1 cnt=1", frame_error, err_count); end
   endtask

   task automatic test_random();
      logic [7:0] fs [4];
      logic [7:0] prev [4];
      logic [7:0] qs [$];
      logic [3:0] qd [$];
      bit have_prev;
      int kind, nb, slot, reps;
      logic [3:0] sel;
      have_prev = 0;
      for (int f = 0; f < 400; f++) begin
         if (have_prev && $urandom_range(0, 2) != 0) fs = prev;
         else begin
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            for (int i = 0; i < 4; i++)
               fs[i] = (i >= 4 - nb) ? 8'hFF : {1'($urandom_range(0, 7) != 0), lut[$urandom_range(0, 9)]};
         end
         prev = fs; have_prev = 1;
         kind = $urandom_range(0, 11);
         slot = $urandom_range(0, 3);
         if (kind == 0) fs[slot] = ($urandom_range(0, 1) == 1) ? 8'hD5 : 8'h6A;
         if (kind == 3) fs[0] = 8'hFF;
         qs.delete(); qd.delete();
         for (int i = 0; i < 4; i++) begin
            if (kind == 2 && i == slot) continue;
            sel = 4'(1 << i);
            if (kind == 1 && i == slot) sel = sel | 4'(1 << ((i + 1) % 4));
            reps = $urandom_range(1, 2);
            for (int r = 0; r < reps; r++) begin
               qs.push_back((r > 0 && $urandom_range(0, 3) == 0) ? {1'b1, lut[$urandom_range(0, 9)]} : fs[i]);
               qd.push_back(sel);
            end
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 2)) begin qs.push_back(8'hFF); qd.push_back(4'b0000); end
         end
         for (int c = 0; c < qs.size(); c++) begin
            drive(qs[c], qd[c]);
            total++;
            if ({value, value_valid, update, dp, frame_error, err_count, stale} !==
                {14'(m_val), m_valid, m_upd, m_dpo, m_ferr, 8'(m_errc), m_stale}) begin
               bad++;
               $display("FAIL random f%0d c%0d: got val=%0d vv=%b upd=%b dp=%h fe=%b cnt=%0d st=%b want val=%0d vv=%b upd=%b dp=%h fe=%b cnt=%0d st=%b",
                        f, c, value, value_valid, update, dp, frame_error, err_count, stale,
                        m_val, m_valid, m_upd, m_dpo, m_ferr, m_errc, m_stale);
            end
         end
      end
   endtask

   task automatic test_saturate();
      repeat (300) drive(8'hFF, 4'b0110);
      drive(8'hFF, 4'b0000);
      drive(8'hFF, 4'b0000);
      total++; if (err_count !== 8'd255) begin bad++; $display("FAIL err_saturate: got %0d want 255", err_count); end
      total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL err_saturate_fe: got %b want 0", frame_error); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_stable();
      test_bad_select();
      test_order_and_blank();
      test_timeout();
      test_reset_mid();
      test_random();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
